// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
//   FB_W_DEF / FB_H_DEF : default framebuffer dimensions
//   ADDR_W              : word address width (covers 160*120 pixels)
//   RGB565_W            : stored pixel width
//   px_entry_t          : one queued write {addr, data}, 31 bits
//   wr_state_t          : writer FSM states
//   rgb888_to_rgb565    : truncating colour conversion
package fb_pkg;
  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int ADDR_W   = 15;
  localparam int RGB565_W = 16;
  localparam int ENTRY_W  = ADDR_W + RGB565_W;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [RGB565_W-1:0] data;
  } px_entry_t;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} wr_state_t;

  function automatic logic [RGB565_W-1:0] rgb888_to_rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Pixel write FIFO, synchronous push/pop, DEPTH a power of two (>= 2).
//   push/wdata : enqueue (ignored when full unless a pop happens at the same edge)
//   pop/rdata  : dequeue; rdata shows the head combinationally
//   full/empty : occupancy flags; count : current occupancy
module pixel_fifo import fb_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  px_entry_t wdata,
  input  logic      pop,
  output px_entry_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  px_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the pop frees the slot the push writes into; the head is read
  // before the edge, so the overwrite is safe.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/framebuffer_pixel_writer.sv
// Framebuffer pixel writer: clips rasterizer pixels, converts RGB888 to
// RGB565, queues them and issues one memory write per pixel.
//   px/py/pixel_color/pixel_valid : incoming pixel (no backpressure)
//   done                          : end-of-shape pulse
//   mem_req/mem_addr/mem_wdata    : write request, held until mem_ack
//   frame_done                    : one-cycle pulse once a shape is fully written
//   busy                          : FIFO non-empty or request outstanding
//   overflow                      : sticky, a pixel was dropped on a full FIFO
//   clip_count                    : saturating count of out-of-range pixels
module framebuffer_pixel_writer import fb_pkg::*; #(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          px,
  input  logic [7:0]          py,
  input  logic [23:0]         pixel_color,
  input  logic                pixel_valid,
  input  logic                done,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [RGB565_W-1:0] mem_wdata,
  input  logic                mem_ack,
  output logic                frame_done,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          clip_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t       state, state_nxt;
  px_entry_t       fifo_din, fifo_dout;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]   fifo_cnt, cnt_nxt;
  logic            clip, in_px, ovf_set;
  logic            done_pending, dp_nxt, fd_fire;

  assign clip    = pixel_valid && ((int'(px) >= FB_W) || (int'(py) >= FB_H));
  assign in_px   = pixel_valid && !clip;
  assign fifo_push = in_px && (!fifo_full || fifo_pop);
  assign ovf_set = in_px && fifo_full && !fifo_pop;

  // FB_W is a constant, so this reduces to shifts and adds.
  assign fifo_din.addr = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
  assign fifo_din.data = rgb888_to_rgb565(pixel_color);

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_din),
    .pop   (fifo_pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          if (!fifo_empty) fifo_pop  = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // frame_done looks at the post-edge occupancy and state so a pixel pushed
  // alongside done, or a final ack at this edge, is accounted for.
  assign cnt_nxt = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
  assign dp_nxt  = done_pending || done;
  assign fd_fire = dp_nxt && (cnt_nxt == '0) && (state_nxt == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done_pending <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      clip_count   <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        mem_addr  <= fifo_dout.addr;
        mem_wdata <= fifo_dout.data;
      end
      frame_done   <= fd_fire;
      done_pending <= dp_nxt && !fd_fire;
      if (ovf_set) overflow <= 1'b1;
      if (clip && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
    end
  end

  assign mem_req = (state == ISSUE);
  assign busy    = !fifo_empty || mem_req;
endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
module tb_framebuffer_pixel_writer;
  logic        clk, rst;
  logic [7:0]  px, py;
  logic [23:0] pixel_color;
  logic        pixel_valid, done, mem_ack;
  logic        mem_req, frame_done, busy, overflow;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  clip_count;

  framebuffer_pixel_writer #(.FB_W(160), .FB_H(120), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .pixel_color(pixel_color),
    .pixel_valid(pixel_valid), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .frame_done(frame_done), .busy(busy),
    .overflow(overflow), .clip_count(clip_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  x, y;
    logic [23:0] c;
    logic [14:0] ea;
    logic [15:0] ed;
    logic        clipped;
    int          ecc;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[10];
  int   tests = 0, fails = 0;
  int   wr_count = 0, fd_count = 0, req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  // Accepted writes are observed mid-cycle, ahead of the edge that takes them.
  always @(negedge clk) begin
    if (mem_req) req_cycles++;
    if (frame_done) fd_count++;
    if (mem_req && mem_ack) begin
      wr_t e;
      wr_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pixel_valid = 1'b0; done = 1'b0; mem_ack = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_px(input int x, input int y, input logic [23:0] c, input logic accept);
    px = 8'(x); py = 8'(y); pixel_color = c; pixel_valid = 1'b1;
    if (accept) exp_q.push_back('{addr: 15'(y * 160 + x), data: to565(c)});
  endtask

  initial begin
    int r0, w0, f0, k4, kf;
    rst = 1'b1; px = '0; py = '0; pixel_color = '0;
    pixel_valid = 1'b0; done = 1'b0; mem_ack = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_clip_count", clip_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    do_reset();

    // Single write latency and one-cycle request with ack held high.
    mem_ack = 1'b1; r0 = req_cycles; w0 = wr_count;
    set_px(3, 2, 24'hFF8000, 1'b1);
    tick(); pixel_valid = 1'b0;
    check("lat_e1_req", mem_req, 0);
    tick();
    check("lat_e2_req", mem_req, 1);
    check("lat_addr", mem_addr, 323);
    check("lat_wdata", mem_wdata, 16'hFC00);
    tick();
    check("lat_e3_req", mem_req, 0);
    tick();
    check("lat_req_cycles", req_cycles - r0, 1);
    check("lat_writes", wr_count - w0, 1);

    // Table vectors: clipping boundaries and colour/address mapping.
    vt[0] = '{8'd0,   8'd0,   24'hFFFFFF, 15'd0,     16'hFFFF, 1'b0, 0};
    vt[1] = '{8'd160, 8'd5,   24'h123456, 15'd0,     16'h0000, 1'b1, 1};
    vt[2] = '{8'd10,  8'd120, 24'h123456, 15'd0,     16'h0000, 1'b1, 2};
    vt[3] = '{8'd159, 8'd119, 24'h000000, 15'd19199, 16'h0000, 1'b0, 2};
    vt[4] = '{8'd255, 8'd255, 24'hABCDEF, 15'd0,     16'h0000, 1'b1, 3};
    vt[5] = '{8'd159, 8'd0,   24'h123456, 15'd159,   16'h11AA, 1'b0, 3};
    vt[6] = '{8'd0,   8'd119, 24'h00FF00, 15'd19040, 16'h07E0, 1'b0, 3};
    vt[7] = '{8'd100, 8'd50,  24'h0000FF, 15'd8100,  16'h001F, 1'b0, 3};
    vt[8] = '{8'd159, 8'd120, 24'hFFFFFF, 15'd0,     16'h0000, 1'b1, 4};
    vt[9] = '{8'd160, 8'd119, 24'hFFFFFF, 15'd0,     16'h0000, 1'b1, 5};
    for (int i = 0; i < 10; i++) begin
      px = vt[i].x; py = vt[i].y; pixel_color = vt[i].c; pixel_valid = 1'b1;
      if (!vt[i].clipped) exp_q.push_back('{addr: vt[i].ea, data: vt[i].ed});
      tick(); pixel_valid = 1'b0;
      repeat (3) tick();
      check($sformatf("vec%0d_clip_count", i), clip_count, vt[i].ecc);
    end
    check("vec_queue_drained", exp_q.size(), 0);

    // Clip counter saturates.
    for (int i = 0; i < 300; i++) begin
      set_px(200, 3, 24'h0, 1'b0);
      tick();
    end
    pixel_valid = 1'b0;
    check("clip_saturate", clip_count, 255);
    check("clip_no_overflow", overflow, 0);

    // Overflow: 1 held + 8 queued, 3 dropped, then drain one per clock.
    do_reset(); w0 = wr_count;
    for (int i = 0; i < 12; i++) begin
      set_px(i, 1, {8'(i * 16), 8'(255 - i * 8), 8'(i * 20)}, i < 9);
      tick();
    end
    pixel_valid = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_held_addr", mem_addr, 160);
    check("ovf_busy", busy, 1);
    mem_ack = 1'b1;
    repeat (9) tick();
    check("ovf_writes", wr_count - w0, 9);
    check("ovf_busy_after", busy, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with pop and push at the same edge.
    do_reset(); w0 = wr_count;
    for (int i = 0; i < 9; i++) begin
      set_px(i, 7, 24'h00FF00 ^ 24'(i), 1'b1);
      tick();
    end
    set_px(9, 7, 24'hF0F0F0, 1'b1);
    mem_ack = 1'b1;
    tick(); pixel_valid = 1'b0;
    repeat (10) tick();
    check("full_pushpop_ovf", overflow, 0);
    check("full_pushpop_writes", wr_count - w0, 10);

    // frame_done after the last of 4 writes, ack every other cycle, repeat done absorbed.
    do_reset(); w0 = wr_count; f0 = fd_count; k4 = -1; kf = -1;
    for (int k = 0; k < 24; k++) begin
      if (k < 4) set_px(20 + k, 9, 24'h808080, 1'b1);
      else pixel_valid = 1'b0;
      done = (k == 4 || k == 6);
      mem_ack = (k % 2 == 1);
      tick();
      if (wr_count - w0 >= 4 && k4 < 0) k4 = k;
      if (frame_done && kf < 0) kf = k;
    end
    done = 1'b0; mem_ack = 1'b0;
    check("fd_writes", wr_count - w0, 4);
    check("fd_pulses", fd_count - f0, 1);
    check("fd_timing", 32'(kf), 32'(k4));

    // Asynchronous reset mid-ISSUE with 3 queued entries; late ack ignored.
    do_reset(); w0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      set_px(i, 30, 24'h4080C0, 1'b0);
      tick();
    end
    pixel_valid = 1'b0;
    check("arst_pre_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req_drop", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, 0);
    mem_ack = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    mem_ack = 1'b0;
    check("arst_no_writes", wr_count - w0, 0);
    check("arst_busy_after", busy, 0);
    check("arst_req_after", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/framebuffer_pixel_writer.md
FRAMEBUFFER_PIXEL_WRITER -- requirements
Module: framebuffer_pixel_writer

Interface
REQ-001 The block SHALL have the following parameter: FB_W, 160, framebuffer width in pixels.
REQ-002 The block SHALL have the following parameter: FB_H, 120, framebuffer height in pixels.
REQ-003 The block SHALL have the following parameter: FIFO_DEPTH, 8, pixel FIFO entries (power of two).
REQ-004 The block SHALL have one clock, clk (input, 1 bit); all state changes on its rising edge.
REQ-005 The block SHALL have rst (input, 1 bit), asynchronous, active-high reset.
REQ-006 The block SHALL have px (input, 8 bits), rasterizer pixel x.
REQ-007 The block SHALL have py (input, 8 bits), rasterizer pixel y.
REQ-008 The block SHALL have pixel_color (input, 24 bits), RGB888 colour, R in [23:16].
REQ-009 The block SHALL have pixel_valid (input, 1 bit), pixel present this cycle; there is no backpressure.
REQ-010 The block SHALL have done (input, 1 bit), one-cycle end-of-shape pulse.
REQ-011 The block SHALL have mem_req (output, 1 bit), write request.
REQ-012 The block SHALL have mem_addr (output, 15 bits), word address.
REQ-013 The block SHALL have mem_wdata (output, 16 bits), RGB565 data.
REQ-014 The block SHALL have mem_ack (input, 1 bit), memory accepted the request this cycle.
REQ-015 The block SHALL have frame_done (output, 1 bit), one-cycle pulse when every pixel of a shape is written.
REQ-016 The block SHALL have busy (output, 1 bit), high while the FIFO is non-empty or mem_req is high.
REQ-017 The block SHALL have overflow (output, 1 bit), sticky flag set when a pixel is dropped because the FIFO is full.
REQ-018 The block SHALL have clip_count (output, 8 bits), saturating count of clipped pixels.

Function
REQ-019 On pixel_valid at edge N, the block SHALL clip the pixel when px>=FB_W or py>=FB_H: it is not enqueued and clip_count increments, saturating at 255.
REQ-020 An in-range pixel SHALL be enqueued as {addr=py*FB_W+px, data={c[23:19],c[15:10],c[7:3]}}.
REQ-021 When the FIFO is full, an in-range pixel SHALL be enqueued only if a pop occurs at the same edge; otherwise it is dropped and overflow is set to 1.
REQ-022 The writer FSM SHALL have two states: IDLE (mem_req=0) and ISSUE (mem_req=1, addr/data held stable).
REQ-023 IDLE SHALL go to ISSUE when the FIFO is non-empty: it pops the head into the output registers, so mem_req is high after the edge following the push (latency 2 edges from pixel_valid).
REQ-024 ISSUE with mem_ack=0 SHALL hold all outputs unchanged.
REQ-025 ISSUE with mem_ack=1 and the FIFO non-empty SHALL pop the next entry and stay in ISSUE, giving a throughput of 1 pixel per clock when ack is continuous.
REQ-026 ISSUE with mem_ack=1 and the FIFO empty SHALL go to IDLE.
REQ-027 mem_ack SHALL be ignored when mem_req=0.
REQ-028 done SHALL set an internal done_pending flag.
REQ-029 When pixel_valid and done are high at the same edge, the pixel SHALL be processed first and done_pending set.
REQ-030 frame_done SHALL pulse high for exactly one cycle at the first edge where done_pending=1, the FIFO is empty and the FSM is in IDLE (after that edge's transitions); done_pending clears at the same edge.
REQ-031 A done arriving while done_pending is already 1 SHALL be absorbed, giving a single frame_done.
REQ-032 overflow SHALL clear only on reset.
REQ-033 clip_count SHALL clear only on reset.

Reset
REQ-034 rst SHALL immediately (asynchronously) force the FSM to IDLE, empty the FIFO, and clear done_pending.
REQ-035 rst SHALL force mem_req=0, mem_addr=0, mem_wdata=0, frame_done=0, busy=0, overflow=0 and clip_count=0.
REQ-036 A reset during ISSUE SHALL abandon the outstanding write; a mem_ack arriving after reset SHALL be ignored.

Structure
REQ-037 Package fb_pkg SHALL hold the FB_W/FB_H defaults, the address width (15), the RGB565 width and the rgb888_to_rgb565 conversion function.
REQ-038 The FIFO SHALL be a separate sub-module, pixel_fifo (31-bit entries, synchronous push/pop, full/empty flags, simultaneous push+pop legal when full).
REQ-039 The address multiply SHALL use the constant FB_W; no general multiplier is needed.

Verification
REQ-040 Scenario: px=3, py=2, color=FF8000, ack held high -> one write with addr=323, wdata=FC00, mem_req high exactly 1 cycle, 2 edges after pixel_valid.
REQ-041 Scenario: px=160, py=5, valid -> no mem_req, clip_count=1; then px=10, py=120 -> clip_count=2.
REQ-042 Scenario: 12 consecutive valid pixels, ack=0 throughout -> 1 held in the output registers, 8 in the FIFO, 3 dropped, overflow=1; then ack=1 -> exactly 9 writes in order.
REQ-043 Scenario: 4 pixels, then done next cycle, ack every other cycle -> frame_done pulses once, on the edge after the 4th ack, never before.
REQ-044 Scenario: rst asserted mid-ISSUE with the FIFO holding 3 entries -> mem_req drops without waiting for a clock edge; after release there are no writes, busy=0, and a late mem_ack has no effect.
REQ-045 Scenario: FIFO full, ack=1 and pixel_valid at the same edge -> the pixel is accepted and overflow stays 0.
